// File: rtl/mrge_pkg.sv
// Shared definitions for the sequential merge sorter: ordering modes,
// controller states and the width helper used for index sizing.
package mrge_pkg;

  localparam logic [1:0] ASC_U = 2'd0;
  localparam logic [1:0] DSC_U = 2'd1;
  localparam logic [1:0] ASC_S = 2'd2;
  localparam logic [1:0] DSC_S = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest s with 2**s >= v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int res;
    res = 0;
    for (int s = 0; s < 31; s++) begin
      if ((32'sd1 <<< s) < v) res = s + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mrge_cmp.sv
// Ordering decision for one merge step: take_a is 1 when a is not after b
// under the selected mode, so equal keys keep the left element first.
module mrge_cmp
  import mrge_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   mode,
  output logic         take_a
);

  // Signed/unsigned compare with direction inversion; ties resolve to a.
  always_comb begin
    take_a = 1'b1;
    case (mode)
      ASC_U:   take_a = (a <= b);
      DSC_U:   take_a = (a >= b);
      ASC_S:   take_a = ($signed(a) <= $signed(b));
      DSC_S:   take_a = ($signed(a) >= $signed(b));
      default: take_a = 1'b1;
    endcase
  end

endmodule

// File: rtl/mrge_seq.sv
// Bottom-up merge sort of N W-bit elements, one compare and one write per
// cycle between two ping-pong register banks, with start/busy/done handshake.
module mrge_seq
  import mrge_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [N*W-1:0] din,
  output logic           busy,
  output logic           done,
  output logic [N*W-1:0] dout
);

  // One extra bit so the run width can reach 2**P without wrapping.
  localparam int IW = clog2(N) + 1;
  localparam int EW = IW + 1;
  localparam logic [EW-1:0] N_E  = EW'(N);
  localparam logic [IW-1:0] N_I  = IW'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  bank_a_r [N];
  logic [W-1:0]  bank_b_r [N];
  logic          src_b_r;
  logic [1:0]    mode_r;
  logic [IW-1:0] r_r;
  logic [IW-1:0] b_r;
  logic [IW-1:0] i_r;
  logic [IW-1:0] j_r;
  logic [IW-1:0] k_r;

  logic [IW-1:0] le_s;
  logic [IW-1:0] re_s;
  logic [IW-1:0] jn_s;
  logic [IW-1:0] jp_s;
  logic [W-1:0]  head_l_s;
  logic [W-1:0]  head_r_s;
  logic [W-1:0]  win_s;
  logic          left_ok_s;
  logic          right_ok_s;
  logic          take_a_s;
  logic          take_left_s;
  logic          blk_end_s;
  logic          pass_end_s;
  logic          final_s;

  function automatic logic [IW-1:0] clip(input logic [EW-1:0] v);
    return (v > N_E) ? N_I : v[IW-1:0];
  endfunction

  mrge_cmp #(.W(W)) u_cmp (
    .a      (head_l_s),
    .b      (head_r_s),
    .mode   (mode_r),
    .take_a (take_a_s)
  );

  // Run bounds, head selection from the source bank and the winner of this step.
  always_comb begin
    le_s     = clip(EW'(b_r) + EW'(r_r));
    re_s     = clip(EW'(b_r) + {r_r, 1'b0});
    jn_s     = clip(EW'(re_s) + EW'(r_r));
    jp_s     = clip({r_r, 1'b0});
    final_s  = ({r_r, 1'b0} >= N_E);
    head_l_s = {W{1'b0}};
    head_r_s = {W{1'b0}};
    for (int e = 0; e < N; e++) begin
      if (i_r == IW'(e)) head_l_s = src_b_r ? bank_b_r[e] : bank_a_r[e];
      if (j_r == IW'(e)) head_r_s = src_b_r ? bank_b_r[e] : bank_a_r[e];
    end
    left_ok_s   = (i_r < le_s);
    right_ok_s  = (j_r < re_s);
    take_left_s = left_ok_s && (!right_ok_s || take_a_s);
    win_s       = take_left_s ? head_l_s : head_r_s;
    pass_end_s  = (k_r == LAST);
    blk_end_s   = ((k_r + IW'(1)) == re_s);
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; a single element needs no merge pass.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = (N == 1) ? DONE : MERGE;
        else       state_s = IDLE;
      end
      MERGE: begin
        if (pass_end_s && final_s) state_s = DONE;
        else                       state_s = MERGE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Banks, run pointers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < N; e++) begin
        bank_a_r[e] <= {W{1'b0}};
        bank_b_r[e] <= {W{1'b0}};
      end
      src_b_r <= 1'b0;
      mode_r  <= 2'd0;
      r_r     <= {IW{1'b0}};
      b_r     <= {IW{1'b0}};
      i_r     <= {IW{1'b0}};
      j_r     <= {IW{1'b0}};
      k_r     <= {IW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      dout    <= {(N*W){1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int e = 0; e < N; e++) bank_a_r[e] <= din[e*W +: W];
            mode_r  <= mode;
            src_b_r <= 1'b0;
            r_r     <= IW'(1);
            b_r     <= {IW{1'b0}};
            i_r     <= {IW{1'b0}};
            j_r     <= clip(EW'(1));
            k_r     <= {IW{1'b0}};
            busy    <= 1'b1;
          end
        end
        MERGE: begin
          for (int e = 0; e < N; e++) begin
            if (k_r == IW'(e)) begin
              if (src_b_r) bank_a_r[e] <= win_s;
              else         bank_b_r[e] <= win_s;
            end
          end
          if (pass_end_s) begin
            src_b_r <= ~src_b_r;
            r_r     <= r_r << 1;
            b_r     <= {IW{1'b0}};
            i_r     <= {IW{1'b0}};
            j_r     <= jp_s;
            k_r     <= {IW{1'b0}};
          end else if (blk_end_s) begin
            k_r <= k_r + IW'(1);
            b_r <= re_s;
            i_r <= re_s;
            j_r <= jn_s;
          end else begin
            k_r <= k_r + IW'(1);
            if (take_left_s) i_r <= i_r + IW'(1);
            else             j_r <= j_r + IW'(1);
          end
        end
        DONE: begin
          for (int e = 0; e < N; e++) dout[e*W +: W] <= src_b_r ? bank_b_r[e] : bank_a_r[e];
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mrge_seq.sv
// Self-checking bench for mrge_seq: three instances (N=5, 8, 1) against a
// cycle-level model built from a reference insertion sort and latency formula.
module tb_mrge_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a [3];
  logic [1:0]   mode_a  [3];
  logic [127:0] din_a   [3];

  logic         busy5, done5, busy8, done8, busy1, done1;
  logic [79:0]  dout5;
  logic [127:0] dout8;
  logic [15:0]  dout1;

  logic         busy_v [3];
  logic         done_v [3];
  logic [127:0] dout_v [3];
  assign busy_v[0] = busy5;
  assign busy_v[1] = busy8;
  assign busy_v[2] = busy1;
  assign done_v[0] = done5;
  assign done_v[1] = done8;
  assign done_v[2] = done1;
  assign dout_v[0] = {48'd0, dout5};
  assign dout_v[1] = dout8;
  assign dout_v[2] = {112'd0, dout1};

  int n_of [3] = '{5, 8, 1};
  int checks = 0;
  int errors = 0;

  mrge_seq #(.N(5), .W(W)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .mode(mode_a[0]),
    .din(din_a[0][79:0]), .busy(busy5), .done(done5), .dout(dout5));
  mrge_seq #(.N(8), .W(W)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .mode(mode_a[1]),
    .din(din_a[1]), .busy(busy8), .done(done8), .dout(dout8));
  mrge_seq #(.N(1), .W(W)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .mode(mode_a[2]),
    .din(din_a[2][15:0]), .busy(busy1), .done(done1), .dout(dout1));

  function automatic logic [127:0] pk(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  // x strictly belongs after y in the given ordering
  function automatic bit after(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m);
    int xv, yv;
    xv = m[1] ? int'($signed(x)) : int'({16'd0, x});
    yv = m[1] ? int'($signed(y)) : int'({16'd0, y});
    return m[0] ? (xv < yv) : (xv > yv);
  endfunction

  function automatic logic [127:0] sort_ref(input logic [127:0] d, input int n, input logic [1:0] m);
    logic [15:0] v [8];
    logic [15:0] t;
    logic [127:0] o;
    int j;
    for (int i = 0; i < 8; i++) v[i] = d[i*16 +: 16];
    for (int i = 1; i < n; i++) begin
      t = v[i];
      j = i;
      while (j > 0 && after(v[j-1], t, m)) begin
        v[j] = v[j-1];
        j = j - 1;
      end
      v[j] = t;
    end
    o = 128'd0;
    for (int i = 0; i < n; i++) o[i*16 +: 16] = v[i];
    return o;
  endfunction

  function automatic int lat_of(input int n);
    int p;
    p = 0;
    while ((1 << p) < n) p = p + 1;
    return p * n + 1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model state
  logic         m_busy [3];
  logic         m_done [3];
  int           m_cnt  [3];
  logic [127:0] m_dout [3];
  logic [127:0] m_pend [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 3; u++) begin
        m_busy[u] <= 1'b0;
        m_done[u] <= 1'b0;
        m_cnt[u]  <= 0;
        m_dout[u] <= 128'd0;
        m_pend[u] <= 128'd0;
      end
    end else begin
      for (int u = 0; u < 3; u++) begin
        m_done[u] <= 1'b0;
        if (!m_busy[u] && start_a[u]) begin
          m_busy[u] <= 1'b1;
          m_cnt[u]  <= lat_of(n_of[u]);
          m_pend[u] <= sort_ref(din_a[u], n_of[u], mode_a[u]);
        end else if (m_busy[u]) begin
          if (m_cnt[u] == 1) begin
            m_busy[u] <= 1'b0;
            m_done[u] <= 1'b1;
            m_dout[u] <= m_pend[u];
          end
          m_cnt[u] <= m_cnt[u] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d busy", u), {127'd0, busy_v[u]}, {127'd0, m_busy[u]});
      chk($sformatf("u%0d done", u), {127'd0, done_v[u]}, {127'd0, m_done[u]});
      chk($sformatf("u%0d dout", u), dout_v[u], m_dout[u]);
    end
  end

  // Launch one sort on unit u and wait for done (or abort with reset at rst_at).
  task automatic run(input int u, input logic [127:0] d, input logic [1:0] m,
                     input logic [127:0] exp, input int exp_lat, input int rst_at,
                     input bit inject, input string nm);
    int c;
    bit fin;
    start_a[u] = 1'b1;
    din_a[u]   = d;
    mode_a[u]  = m;
    @(negedge clk);
    start_a[u] = 1'b0;
    din_a[u]   = ~d;
    mode_a[u]  = ~m;
    c   = 1;
    fin = 1'b0;
    while (!fin) begin
      if (done_v[u]) begin
        chk({nm, " latency"}, 128'(c - 1), 128'(exp_lat));
        chk({nm, " result"}, dout_v[u], exp);
        fin = 1'b1;
      end else if (c == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, " reset busy"}, {127'd0, busy_v[u]}, 128'd0);
        chk({nm, " reset done"}, {127'd0, done_v[u]}, 128'd0);
        chk({nm, " reset dout"}, dout_v[u], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
      end else if (c > 200) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s timeout: no done after %0d cycles, expected %0d", nm, c, exp_lat);
        fin = 1'b1;
      end else begin
        if (inject && (c == 3 || c == 10)) begin
          start_a[u] = 1'b1;
          din_a[u]   = pk(16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600, 16'd700, 16'd800);
          mode_a[u]  = 2'd1;
        end else begin
          start_a[u] = 1'b0;
        end
        @(negedge clk);
        c = c + 1;
      end
    end
    start_a[u] = 1'b0;
  endtask

  logic [127:0] d1, d2, d8;

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_a[u] = 1'b0;
      mode_a[u]  = 2'd0;
      din_a[u]   = 128'd0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d init busy", u), {127'd0, busy_v[u]}, 128'd0);
      chk($sformatf("u%0d init done", u), {127'd0, done_v[u]}, 128'd0);
      chk($sformatf("u%0d init dout", u), dout_v[u], 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    d1 = pk(16'd26, 16'd16, 16'd35, 16'd6, 16'd46, 16'd0, 16'd0, 16'd0);
    d2 = pk(16'hFFFF, 16'd5, 16'h8000, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0);
    d8 = pk(16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0);

    run(0, d1, 2'd0, pk(16'd6, 16'd16, 16'd26, 16'd35, 16'd46, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "asc_u");
    run(0, d1, 2'd1, pk(16'd46, 16'd35, 16'd26, 16'd16, 16'd6, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "dsc_u");
    run(0, d1, 2'd2, pk(16'd6, 16'd16, 16'd26, 16'd35, 16'd46, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "asc_s_pos");
    run(0, d2, 2'd2, pk(16'h8000, 16'hFFFF, 16'd0, 16'd3, 16'd5, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "asc_s_neg");
    run(0, d2, 2'd0, pk(16'd0, 16'd3, 16'd5, 16'h8000, 16'hFFFF, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "asc_u_big");
    run(0, d2, 2'd3, pk(16'd5, 16'd3, 16'd0, 16'hFFFF, 16'h8000, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "dsc_s");
    run(1, d8, 2'd0, pk(16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7), 25, 0, 1'b1, "n8_ignore");
    run(0, d1, 2'd0, 128'd0, 0, 8, 1'b0, "abort");
    run(0, d1, 2'd0, pk(16'd6, 16'd16, 16'd26, 16'd35, 16'd46, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "after_rst");
    run(2, pk(16'h1234, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0), 2'd1,
        pk(16'h1234, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0), 1, 0, 1'b0, "n1");
    run(0, pk(16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd0, 16'd0, 16'd0), 2'd3,
        pk(16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd0, 16'd0, 16'd0), 16, 0, 1'b0, "ties");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrge_seq.md
# mrge_seq

Parametrised, sequential successor to the fixed 5×16-bit `mrge` sorter. It sorts N elements of W bits with a bottom-up merge sort that does one compare and one write per cycle, using ping-pong register banks. It adds a start/busy/done handshake, signed and unsigned ordering, and both sort directions. It sits between a parallel data producer and a consumer that samples `dout` on `done`.

## Interface
- `N`, 5: element count, 1..64
- `W`, 16: element width in bits, 2..32
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request a sort; sampled only in IDLE
- `mode` in 2: ordering, captured with `start`. 0 = ascending unsigned, 1 = descending unsigned, 2 = ascending signed, 3 = descending signed (two's complement)
- `din` in N*W: element i is `din[i*W +: W]`; captured with `start`
- `busy` out 1: high from the cycle after `start` is accepted until `done`
- `done` out 1: one-cycle pulse; `dout` is valid from that cycle
- `dout` out N*W: sorted result; element 0 comes first in the selected order

## Operation
- States are IDLE, MERGE and DONE. Reset forces IDLE with `busy`=0, `done`=0, `dout`=0 and both banks cleared.
- **IDLE to MERGE.** On a `start`=1 edge:
  - load `din` into bank A;
  - latch `mode`;
  - set run width r=1, the pass counter and the write index k=0.
  - If N=1, go straight to DONE instead.
- **MERGE, per cycle.** Write one element into the destination bank at index k.
  - Candidates are the heads of the left run [b, b+r) and the right run [b+r, b+2r) in the source bank. Both runs are clipped to N, and a right run may be empty.
  - The left head wins when it is "not after" the right head under `mode`. Ties take the left head, so the sort is stable.
  - An exhausted run always yields to the other run.
  - k increments every cycle. When k reaches a block boundary (b+2r or N), the run pointers reset for the next block.
- **End of pass.** After N writes:
  - swap the source and destination banks;
  - set r ← 2r;
  - if r ≥ N, latch the final bank into `dout` and go to DONE.
- **DONE.** `done`=1 for exactly one cycle, then return to IDLE. `dout` holds its value until the next result or reset.
- `start` is ignored while in MERGE or DONE; there is no queueing.
- `start` may be asserted in the same cycle that IDLE is re-entered.
- `mode` and `din` changes are ignored after capture.
- Reset mid-operation aborts immediately. All outputs and state return to their reset values.

## Timing
- P = ceil(log2 N), with P=0 for N=1.
- Capture happens at the start edge (edge 0). MERGE occupies edges 1..P*N. `done` is high in the cycle after edge P*N+1, which is the cycle after edge 1 when N=1.
- Latency from the start edge to `done` is P*N+1 cycles:
  - N=5: 16 cycles;
  - N=8: 25 cycles.
- `busy` is high for P*N+1 cycles and drops in the same cycle `done` rises.
- The earliest back-to-back `start` is in the `done` cycle +1. Throughput is one sort per P*N+2 cycles.

## Structure
- `mrge_pkg` holds:
  - the mode encodings (ASC_U, DSC_U, ASC_S, DSC_S);
  - the state enum;
  - a `clog2` function for the pass count and index widths.
- Sub-module `mrge_cmp` (combinational) takes inputs a, b and mode and outputs `take_a`.
  - It handles signed versus unsigned comparison and direction inversion.
  - Ties return 1.
- Banks are N×W register arrays. The index, pointer and run-width registers are clog2(N)+1 bits wide, so that r=2^P does not overflow.

## Test plan
- N=5, W=16, din = {26, 16, 35, 6, 46} (element 0 first), mode=0 → `dout` = {6, 16, 26, 35, 46}, `done` 16 cycles after the start edge, `busy` high for 16 cycles.
- Same din with mode=1 → {46, 35, 26, 16, 6}. Then with mode=2 → {6, 16, 26, 35, 46} (all values are positive).
- din = {0xFFFF, 5, 0x8000, 3, 0}:
  - mode=2 → {0x8000, 0xFFFF, 0, 3, 5};
  - mode=0 → {0, 3, 5, 0x8000, 0xFFFF}.
- N=8, din = {7, 6, 5, 4, 3, 2, 1, 0}, mode=0 → {0..7}, `done` at 25 cycles. Pulse `start` with new data and mode=1 at cycles 3 and 10 → both ignored, and the result is unchanged.
- N=5 sort in progress, deassert `rst_n` at cycle 8 → `busy`, `done` and `dout` are 0 immediately. After release, a new `start` sorts correctly with the full 16-cycle latency.
- N=1, din = 0x1234 → `done` 1 cycle after start, `dout` = 0x1234. Then N=5 with all elements = 9 → `dout` is all 9s, 16 cycles.
